// File: rtl/multi_issue_decode_ctrl_pkg.sv
// decode_pkg: shared definitions for the multi-issue decode controller.
//   - opcode encodings (4-bit opcode taken from the top nibble of an instruction)
//   - CTRL_W and the bit index of every field in the per-lane control vector
//   - FSM state encoding and a branch-class helper
package decode_pkg;

    localparam int CTRL_W = 16;

    typedef enum logic [3:0] {
        OP_NOP     = 4'h0,
        OP_ADD     = 4'h1,
        OP_SUB     = 4'h2,
        OP_MUL     = 4'h3,
        OP_LD      = 4'h4,
        OP_ST      = 4'h5,
        OP_CMP     = 4'h6,
        OP_MOV     = 4'h7,
        OP_OR      = 4'h8,
        OP_AND     = 4'h9,
        OP_NOT     = 4'hA,
        OP_LSL     = 4'hB,
        OP_UBRANCH = 4'hC,
        OP_LSR     = 4'hD,
        OP_BEQ     = 4'hE,
        OP_BGT     = 4'hF
    } opcode_e;

    // Control vector bit positions
    localparam int B_ADD     = 0;
    localparam int B_SUB     = 1;
    localparam int B_MUL     = 2;
    localparam int B_LD      = 3;
    localparam int B_ST      = 4;
    localparam int B_CMP     = 5;
    localparam int B_MOV     = 6;
    localparam int B_OR      = 7;
    localparam int B_AND     = 8;
    localparam int B_NOT     = 9;
    localparam int B_LSL     = 10;
    localparam int B_LSR     = 11;
    localparam int B_BEQ     = 12;
    localparam int B_BGT     = 13;
    localparam int B_UBRANCH = 14;
    localparam int B_WB      = 15;

    // RUN: skid empty, accepting. HOLD: skid holds one bundle.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_UBRANCH) || (op == OP_BEQ) || (op == OP_BGT);
    endfunction

endpackage

// File: rtl/multi_issue_decode_ctrl_if.sv
// Bundle handshake between an instruction source and the decode controller.
//   flush, stall          : source -> decoder control
//   in_valid, in_instr    : instruction bundle (lane 0 oldest)
//   in_ready              : decoder -> source, bundle accepted when high
//   out_valid, out_ctrl   : decoded per-lane valid and control vectors
// master = instruction source / bench side, slave = decode controller.
interface multi_issue_decode_ctrl_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int INSTR_W     = 16
) ();
    logic                                      flush;
    logic                                      stall;
    logic [ISSUE_WIDTH-1:0]                    in_valid;
    logic [ISSUE_WIDTH*INSTR_W-1:0]            in_instr;
    logic                                      in_ready;
    logic [ISSUE_WIDTH-1:0]                    out_valid;
    logic [ISSUE_WIDTH*decode_pkg::CTRL_W-1:0] out_ctrl;

    modport master (
        output flush, stall, in_valid, in_instr,
        input  in_ready, out_valid, out_ctrl
    );

    modport slave (
        input  flush, stall, in_valid, in_instr,
        output in_ready, out_valid, out_ctrl
    );
endinterface

// File: rtl/multi_issue_decode_ctrl_decode_lane.sv
// decode_lane: purely combinational opcode -> control vector decoder.
//   opcode : 4-bit opcode
//   ctrl   : CTRL_W-bit one-hot operation field plus WB flag (NOP -> all zero)
module decode_lane
    import decode_pkg::*;
(
    input  logic [3:0]        opcode,
    output logic [CTRL_W-1:0] ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_ADD:     begin ctrl[B_ADD] = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_SUB:     begin ctrl[B_SUB] = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_MUL:     begin ctrl[B_MUL] = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_LD:      begin ctrl[B_LD]  = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_ST:      ctrl[B_ST]  = 1'b1;
            OP_CMP:     ctrl[B_CMP] = 1'b1;
            OP_MOV:     begin ctrl[B_MOV] = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_OR:      begin ctrl[B_OR]  = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_AND:     begin ctrl[B_AND] = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_NOT:     begin ctrl[B_NOT] = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_LSL:     begin ctrl[B_LSL] = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_UBRANCH: ctrl[B_UBRANCH] = 1'b1;
            OP_LSR:     begin ctrl[B_LSR] = 1'b1; ctrl[B_WB] = 1'b1; end
            OP_BEQ:     ctrl[B_BEQ] = 1'b1;
            OP_BGT:     ctrl[B_BGT] = 1'b1;
            default:    ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_issue_decode_ctrl.sv
// multi_issue_decode_ctrl: registered multi-lane instruction decoder with a
// one-bundle skid buffer, flush priority and a saturating stall counter.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of multi_issue_decode_ctrl_if (flush, stall,
//                in_valid/in_instr/in_ready, out_valid/out_ctrl)
//   stall_cnt  : saturating count of stalled cycles with a valid output
// Optional feature: define DECODE_BRANCH_SQUASH_EN to invalidate every lane
// younger than the oldest valid branch lane of a decoded bundle.
module multi_issue_decode_ctrl
    import decode_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int INSTR_W     = 16,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    multi_issue_decode_ctrl_if.slave bus,
    output logic [CNT_W-1:0]         stall_cnt
);

    state_e state_q, state_d;
    logic   load_out, from_skid, capture, clear_out;

    logic [ISSUE_WIDTH-1:0]         skid_valid_q;
    logic [ISSUE_WIDTH*INSTR_W-1:0] skid_instr_q;

    logic [ISSUE_WIDTH-1:0]         sel_valid_p0, dec_valid_p0;
    logic [ISSUE_WIDTH*INSTR_W-1:0] sel_instr_p0;
    logic [ISSUE_WIDTH*CTRL_W-1:0]  dec_ctrl_p0;

    logic [ISSUE_WIDTH-1:0]         valid_p1;
    logic [ISSUE_WIDTH*CTRL_W-1:0]  ctrl_p1;
    logic [CNT_W-1:0]               stall_cnt_q;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Next state and load controls; flush overrides everything
    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        from_skid = 1'b0;
        capture   = 1'b0;
        clear_out = 1'b0;
        if (bus.flush) begin
            state_d   = ST_RUN;
            clear_out = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!bus.stall) begin
                        load_out = 1'b1;
                    end else if (|bus.in_valid) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!bus.stall) begin
                        load_out  = 1'b1;
                        from_skid = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // in_ready depends on state only, never on stall
    assign bus.in_ready = (state_q == ST_RUN);

    // Stage p0: select input or skid bundle and decode
    assign sel_valid_p0 = from_skid ? skid_valid_q : bus.in_valid;
    assign sel_instr_p0 = from_skid ? skid_instr_q : bus.in_instr;

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
        decode_lane u_lane (
            .opcode (sel_instr_p0[g*INSTR_W + INSTR_W-1 -: 4]),
            .ctrl   (dec_ctrl_p0[g*CTRL_W +: CTRL_W])
        );
    end

    always_comb begin
`ifdef DECODE_BRANCH_SQUASH_EN
        logic br_seen;
        br_seen      = 1'b0;
        dec_valid_p0 = sel_valid_p0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (br_seen) begin
                dec_valid_p0[i] = 1'b0;
            end else if (sel_valid_p0[i] &&
                         is_branch(sel_instr_p0[i*INSTR_W + INSTR_W-1 -: 4])) begin
                br_seen = 1'b1;
            end
        end
`else
        dec_valid_p0 = sel_valid_p0;
`endif
    end

    // Skid capture: holds the bundle offered while stalled in RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= '0;
            skid_instr_q <= '0;
        end else if (capture) begin
            skid_valid_q <= bus.in_valid;
            skid_instr_q <= bus.in_instr;
        end
    end

    // Stage p1: output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_p1 <= '0;
            ctrl_p1  <= '0;
        end else if (clear_out) begin
            valid_p1 <= '0;
            ctrl_p1  <= '0;
        end else if (load_out) begin
            valid_p1 <= dec_valid_p0;
            ctrl_p1  <= dec_ctrl_p0;
        end
    end

    assign bus.out_valid = valid_p1;
    assign bus.out_ctrl  = ctrl_p1;

    // Stall counter saturates at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (bus.stall && !bus.flush && (|valid_p1) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_multi_issue_decode_ctrl.sv
// Testbench for multi_issue_decode_ctrl (ISSUE_WIDTH=2, INSTR_W=16, CNT_W=4).
// Stimulus pushes the reference model's expected response into a queue; a
// monitor pops one entry per clock and compares it with the DUT outputs.
module tb_multi_issue_decode_ctrl;

    localparam int IW = 2;
    localparam int CW = 4;

    typedef struct packed {
        logic [IW-1:0] vld;
        logic [31:0]   ctrl;
        logic          rdy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] stall_cnt;

    multi_issue_decode_ctrl_if #(.ISSUE_WIDTH(IW), .INSTR_W(16)) bus ();

    multi_issue_decode_ctrl #(
        .ISSUE_WIDTH (IW),
        .INSTR_W     (16),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;
    exp_t sb_q[$];

    // Reference model state
    logic [IW-1:0] m_vld;
    logic [31:0]   m_ctrl;
    bit            m_pend;
    logic [IW-1:0] m_pv;
    logic [31:0]   m_pi;
    int            m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control vector from the opcode table: one operation bit plus WB.
    function automatic logic [15:0] model_ctrl(input logic [3:0] op);
        int pos[16] = '{-1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 14, 11, 12, 13};
        logic [15:0] c;
        c = '0;
        if (pos[op] >= 0) c[pos[op]] = 1'b1;
        if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD})
            c[15] = 1'b1;
        return c;
    endfunction

    task automatic set_out(input logic [IW-1:0] v, input logic [31:0] instr);
        int first_br;
        first_br = IW;
        for (int l = 0; l < IW; l++) begin
            m_ctrl[l*16 +: 16] = model_ctrl(instr[l*16 + 12 +: 4]);
            if (first_br == IW && v[l] && (instr[l*16 + 12 +: 4] inside {4'hC, 4'hE, 4'hF}))
                first_br = l;
        end
        m_vld = v;
`ifdef DECODE_BRANCH_SQUASH_EN
        for (int l = 0; l < IW; l++)
            if (l > first_br) m_vld[l] = 1'b0;
`endif
    endtask

    // Drive one cycle of inputs and record what the DUT must show after the next edge.
    task automatic apply(input bit r, input bit f, input bit s, input logic [IW-1:0] v,
                         input logic [15:0] i0, input logic [15:0] i1);
        exp_t e;
        reset        = r;
        bus.flush    = f;
        bus.stall    = s;
        bus.in_valid = v;
        bus.in_instr = {i1, i0};
        if (r) begin
            m_vld = '0; m_ctrl = '0; m_pend = 1'b0; m_cnt = 0;
        end else begin
            if (s && !f && m_vld != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
            if (f) begin
                m_vld = '0; m_ctrl = '0; m_pend = 1'b0;
            end else if (!m_pend) begin
                if (!s) set_out(v, {i1, i0});
                else if (v != 0) begin
                    m_pend = 1'b1; m_pv = v; m_pi = {i1, i0};
                end
            end else if (!s) begin
                set_out(m_pv, m_pi);
                m_pend = 1'b0;
            end
        end
        e.vld  = m_vld;
        e.ctrl = m_ctrl;
        e.rdy  = !m_pend;
        e.cnt  = m_cnt[CW-1:0];
        sb_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares once per clock, 1 time unit after the edge.
    initial begin
        exp_t e;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty actual=empty expected=entry at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_out_valid", 32'(bus.out_valid), 32'(e.vld));
                chk("sb_out_ctrl",  bus.out_ctrl, e.ctrl);
                chk("sb_in_ready",  32'(bus.in_ready), 32'(e.rdy));
                chk("sb_stall_cnt", 32'(stall_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.stall    = 1'b0;
        bus.in_valid = '0;
        bus.in_instr = '0;
        m_vld = '0; m_ctrl = '0; m_pend = 1'b0; m_pv = '0; m_pi = '0; m_cnt = 0;

        tick(); apply(1, 0, 0, 2'b00, 16'h0, 16'h0);
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        apply(0, 0, 0, 2'b00, 16'h0, 16'h0);

        // ADD / ST bundle
        tick(); apply(0, 0, 0, 2'b11, 16'h1234, 16'h5000);
        tick();
        chk("d1_out_valid", 32'(bus.out_valid), 32'h3);
        chk("d1_ctrl0", 32'(bus.out_ctrl[15:0]), 32'h8001);
        chk("d1_ctrl1", 32'(bus.out_ctrl[31:16]), 32'h0010);

        // Stall in RUN captures into skid, release replays it
        apply(0, 0, 1, 2'b11, 16'h3000, 16'h7000);
        tick();
        chk("d2_in_ready_hold", 32'(bus.in_ready), 32'd0);
        chk("d2_ctrl0_hold", 32'(bus.out_ctrl[15:0]), 32'h8001);
        apply(0, 0, 0, 2'b00, 16'h0, 16'h0);
        tick();
        chk("d2_ctrl0_replay", 32'(bus.out_ctrl[15:0]), 32'h8004);
        chk("d2_ctrl1_replay", 32'(bus.out_ctrl[31:16]), 32'h8040);
        chk("d2_in_ready_after", 32'(bus.in_ready), 32'd1);

        // Flush with stall while in HOLD
        apply(0, 0, 1, 2'b11, 16'h2000, 16'h8000);
        tick(); apply(0, 1, 1, 2'b11, 16'h9000, 16'h9000);
        tick();
        chk("d3_out_valid_flush", 32'(bus.out_valid), 32'd0);
        chk("d3_in_ready_flush", 32'(bus.in_ready), 32'd1);
        apply(0, 0, 0, 2'b00, 16'h0, 16'h0);
        tick();
        chk("d3_no_replay", 32'(bus.out_valid), 32'd0);

        // Branch in the oldest lane
        apply(0, 0, 0, 2'b11, 16'hE000, 16'h1000);
        tick();
`ifdef DECODE_BRANCH_SQUASH_EN
        chk("d4_out_valid_squash", 32'(bus.out_valid), 32'h1);
`else
        chk("d4_out_valid_nosquash", 32'(bus.out_valid), 32'h3);
`endif
        chk("d4_ctrl0", 32'(bus.out_ctrl[15:0]), 32'h1000);

        // Stall counter saturation, then reset
        for (int k = 0; k < 20; k++) begin
            apply(0, 0, 1, 2'b00, 16'h0, 16'h0);
            tick();
        end
        chk("d5_cnt_sat", 32'(stall_cnt), 32'hF);
        apply(1, 0, 0, 2'b00, 16'h0, 16'h0);
        tick();
        chk("d5_cnt_reset", 32'(stall_cnt), 32'd0);

        // Reset while in HOLD discards the skid bundle
        apply(0, 0, 1, 2'b11, 16'h1000, 16'h2000);
        tick();
        chk("d6_hold_ready", 32'(bus.in_ready), 32'd0);
        apply(1, 0, 1, 2'b00, 16'h0, 16'h0);
        tick();
        chk("d6_rst_ready", 32'(bus.in_ready), 32'd1);
        apply(0, 0, 0, 2'b00, 16'h0, 16'h0);
        tick();
        chk("d6_no_replay0", 32'(bus.out_valid), 32'd0);
        apply(0, 0, 0, 2'b00, 16'h0, 16'h0);
        tick();
        chk("d6_no_replay1", 32'(bus.out_valid), 32'd0);
        apply(0, 0, 0, 2'b11, 16'h7000, 16'h7000);
        tick();
        chk("d6_new_bundle", 32'(bus.out_valid), 32'h3);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            bit            r, f, s;
            logic [IW-1:0] v;
            logic [15:0]   a, b;
            r = ($urandom_range(0, 79) == 0);
            f = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 2) == 0);
            v = IW'($urandom_range(0, 3));
            a = 16'($urandom);
            b = 16'($urandom);
            apply(r, f, s, v, a, b);
            tick();
        end
        apply(0, 0, 0, 2'b00, 16'h0, 16'h0);

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_issue_decode_ctrl.md
MULTI_ISSUE_DECODE_CTRL -- requirements
Module: multi_issue_decode_ctrl

Interface
REQ-001 The block SHALL have parameter ISSUE_WIDTH, default 2, meaning the number of decode lanes per bundle (1..4).
REQ-002 The block SHALL have parameter INSTR_W, default 16, meaning the instruction width; the opcode is bits [INSTR_W-1 -: 4].
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  branch-taken flush.
- stall  in  1  downstream not accepting.
- in_valid  in  ISSUE_WIDTH  per-lane instruction valid.
- in_instr  in  ISSUE_WIDTH*INSTR_W  instruction bundle; lane 0 is oldest.
- in_ready  out  1  bundle accepted this cycle when high with any in_valid.
- out_valid  out  ISSUE_WIDTH  per-lane decoded valid.
- out_ctrl  out  ISSUE_WIDTH*16  per-lane control vector, layout per REQ-020.
- stall_cnt  out  CNT_W  saturating count of stall cycles with out_valid nonzero.

Function
REQ-005 Decode SHALL be registered; the latency from accepted input to out_valid/out_ctrl SHALL be 1 cycle.
REQ-006 Decode map: 1 ADD, 2 SUB, 3 MUL, 4 LD, 5 ST, 6 CMP, 7 MOV, 8 OR, 9 AND, A NOT, B LSL, C UBRANCH, D LSR, E BEQ, F BGT.
REQ-007 WB SHALL be set for ADD, SUB, MUL, LD, MOV, OR, AND, NOT, LSL and LSR, and clear for ST, CMP, UBRANCH, BEQ and BGT.
REQ-008 Opcode 0 SHALL decode as NOP: the ctrl vector is all zero and the lane's out_valid follows in_valid.
REQ-009 The block SHALL use a two-state FSM: RUN (skid empty) and HOLD (skid holds one bundle).
REQ-010 in_ready SHALL equal (state==RUN); it is combinational from state only, with no dependence on stall.
REQ-011 In RUN with stall=0, the output registers SHALL load decode(in_instr) with out_valid=in_valid.
REQ-012 In RUN with stall=1, the outputs SHALL hold; a bundle with any in_valid SHALL be captured into the skid and the state SHALL go to HOLD; with no valid input the state SHALL stay RUN.
REQ-013 In HOLD with stall=1, the outputs and the skid SHALL hold.
REQ-014 In HOLD with stall=0, the outputs SHALL load decode(skid) and the state SHALL go to RUN; in_ready is low that cycle, so no input is lost.
REQ-015 flush SHALL have priority over stall: next cycle out_valid=0, out_ctrl=0 and state=RUN, and any bundle presented that cycle SHALL be dropped.
REQ-016 stall_cnt SHALL increment when stall=1, flush=0 and out_valid is nonzero, saturating at all-ones without wrap.

Reset
REQ-017 Asynchronous reset SHALL force out_valid=0, out_ctrl=0, stall_cnt=0, skid cleared and state=RUN; in_ready SHALL be 1 during and after reset.
REQ-018 Reset asserted mid-HOLD SHALL discard the skid bundle, with no replay after release.

Configuration
REQ-019 Macro DECODE_BRANCH_SQUASH_EN:
- Defined: in a decoded bundle, any lane younger than the oldest lane decoding UBRANCH, BEQ or BGT SHALL have out_valid forced to 0; the squash applies identically to the skid replay path.
- Undefined: all lanes pass unaltered.

Structure
REQ-020 Package decode_pkg SHALL hold the opcode constants, CTRL_W=16 and the ctrl bit indices: [0] ADD, [1] SUB, [2] MUL, [3] LD, [4] ST, [5] CMP, [6] MOV, [7] OR, [8] AND, [9] NOT, [10] LSL, [11] LSR, [12] BEQ, [13] BGT, [14] UBRANCH, [15] WB.
REQ-021 Sub-module decode_lane SHALL be purely combinational (opcode -> 16-bit ctrl) and SHALL be instantiated ISSUE_WIDTH times. The FSM, skid, squash and counter SHALL stay in the top level.

Verification
REQ-022 The bench SHALL cover these directed scenarios (ISSUE_WIDTH=2):
- in_valid=11, lanes {0x1234, 0x5000}, stall=0 -> next cycle out_valid=11, lane0 ctrl=0x8001, lane1 ctrl=0x0010.
- stall=1 with bundle {0x3000, 0x7000} in RUN -> outputs hold, state HOLD, in_ready=0; stall drops -> out ctrl {0x8004, 0x8040}, in_ready=1 the following cycle.
- flush and stall together while in HOLD -> next cycle out_valid=00, in_ready=1, skid bundle never appears.
- With DECODE_BRANCH_SQUASH_EN, bundle {0xE000, 0x1000} -> out_valid=01, lane0 ctrl=0x1000; without the macro -> out_valid=11.
- CNT_W=4, stall held 20 cycles with valid outputs -> stall_cnt=0xF, no wrap; reset -> 0.
- Reset pulse mid-HOLD, then stall=0 -> out_valid stays 00 until a new bundle is accepted.
